// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator call scheduler:
//   - state_e      : scheduler FSM state encoding
//   - FLOOR_W_DEF  : default width of floor-index buses
//   - F1 / F2 / F3 : floor labels (F1 is the ground floor, index 0)
// No ports (package).
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int FLOOR_W_DEF = 2;

  localparam int F1 = 0;
  localparam int F2 = 1;
  localparam int F3 = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPATCH = 3'd1,
    ST_MOVING   = 3'd2,
    ST_DWELL    = 3'd3,
    ST_SOS      = 3'd4
  } state_e;

endpackage

// File: rtl/call_scheduler_if.sv
// -----------------------------------------------------------------------------
// call_scheduler_if
// Goal handshake between the call scheduler and the car movement block.
//   goal_floor : target floor offered by the scheduler
//   goal_valid : goal_floor is valid and waiting for acceptance
//   goal_ack   : movement block accepts goal_floor
// Modports: master = scheduler side, slave = movement block side.
// -----------------------------------------------------------------------------
interface call_scheduler_if
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_DEF
);

  logic [FLOOR_W-1:0] goal_floor;
  logic               goal_valid;
  logic               goal_ack;

  modport master (
    output goal_floor,
    output goal_valid,
    input  goal_ack
  );

  modport slave (
    input  goal_floor,
    input  goal_valid,
    output goal_ack
  );

endinterface

// File: rtl/call_picker.sv
// -----------------------------------------------------------------------------
// call_picker
// Combinational SCAN target selection.
// Ports:
//   call_led   in  : pending calls, one bit per floor
//   cur_floor  in  : current car floor (out-of-range values act as floor 0)
//   dir_up     in  : current sweep direction
//   pick_floor out : selected target floor
//   pick_valid out : a target was found
//   dir_next   out : sweep direction to adopt with pick_floor
// Nearest pending floor in the sweep direction wins; otherwise the direction
// flips and the nearest pending floor the other way is taken. A call pending
// for the floor the car is already at is picked only when nothing else is
// pending, so such a call can never be stranded.
// -----------------------------------------------------------------------------
module call_picker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] call_led,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  pick_valid,
  output logic                  dir_next
);

  logic [FLOOR_W-1:0]    cur_eff;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] here_mask;
  logic [FLOOR_W-1:0]    up_floor;
  logic [FLOOR_W-1:0]    dn_floor;

  assign cur_eff = (int'(cur_floor) >= NUM_FLOORS) ? '0 : cur_floor;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
      assign above_mask[gi] = call_led[gi] && (gi > int'(cur_eff));
      assign below_mask[gi] = call_led[gi] && (gi < int'(cur_eff));
      assign here_mask[gi]  = call_led[gi] && (gi == int'(cur_eff));
    end
  endgenerate

  // Nearest above = lowest set bit of above_mask (scan downwards, last hit wins).
  // Nearest below = highest set bit of below_mask (scan upwards, last hit wins).
  always_comb begin
    up_floor = '0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above_mask[i]) up_floor = FLOOR_W'(i);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below_mask[i]) dn_floor = FLOOR_W'(i);
    end
  end

  always_comb begin
    pick_floor = cur_eff;
    pick_valid = 1'b0;
    dir_next   = dir_up;
    if (dir_up) begin
      if (|above_mask) begin
        pick_floor = up_floor;
        pick_valid = 1'b1;
      end else if (|below_mask) begin
        pick_floor = dn_floor;
        pick_valid = 1'b1;
        dir_next   = 1'b0;
      end else if (|here_mask) begin
        pick_valid = 1'b1;
      end
    end else begin
      if (|below_mask) begin
        pick_floor = dn_floor;
        pick_valid = 1'b1;
      end else if (|above_mask) begin
        pick_floor = up_floor;
        pick_valid = 1'b1;
        dir_next   = 1'b1;
      end else if (|here_mask) begin
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// -----------------------------------------------------------------------------
// call_scheduler
// Latches hall/car calls and dispatches target floors to the movement block
// using SCAN (elevator) ordering, with a dwell period at each served floor.
// Ports:
//   clk          in  : clock, rising edge
//   reset_n      in  : asynchronous active-low reset
//   call_req     in  : call button per floor (level)
//   cur_floor    in  : current car floor
//   arrived      in  : one-cycle pulse when the car stops at cur_floor
//   weight_over  in  : car overloaded (level), blocks dispatch, extends dwell
//   sos_req      in  : emergency recall to floor 0 (level)
//   goal_bus     master modport of call_scheduler_if (goal_floor/valid/ack)
//   call_led     out : latched pending calls
//   dir_up       out : current sweep direction (1 = up)
//   busy         out : high in every state except IDLE
// Configuration:
//   CALL_SCHEDULER_SOS_EN defined  -> emergency recall enabled.
//   CALL_SCHEDULER_SOS_EN undefined -> sos_req is ignored, SOS unreachable.
// -----------------------------------------------------------------------------
module call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 3,
  parameter int FLOOR_W      = FLOOR_W_DEF,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  input  logic                  weight_over,
  input  logic                  sos_req,
  call_scheduler_if.master      goal_bus,
  output logic [NUM_FLOORS-1:0] call_led,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e                state_reg;
  logic [NUM_FLOORS-1:0] call_led_reg;
  logic [FLOOR_W-1:0]    goal_floor_reg;
  logic                  goal_valid_reg;
  logic                  dir_up_reg;
  logic [CNT_W-1:0]      dwell_cnt_reg;
  logic                  sos_home_reg;

  logic [FLOOR_W-1:0]    pick_floor;
  logic                  pick_valid;
  logic                  dir_next;

  logic [NUM_FLOORS-1:0] call_set;
  logic [NUM_FLOORS-1:0] call_clr;
  logic [NUM_FLOORS-1:0] here_req;
  logic                  block_here;
  logic                  arrive_goal;
  logic                  serving_call;
  logic                  sos_enter;
  logic                  sos_level;

  // ---------------------------------------------------------------------------
  // Emergency recall gating
  // ---------------------------------------------------------------------------
`ifdef CALL_SCHEDULER_SOS_EN
  assign sos_level = sos_req;
  // Only the first cycle of a recall reloads the goal; once in SOS the
  // handshake runs normally so goal_valid can drop after goal_ack.
  assign sos_enter = sos_req && (state_reg != ST_SOS);
`else
  logic sos_unused;
  assign sos_unused = sos_req;
  assign sos_level  = 1'b0;
  assign sos_enter  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // SCAN selection
  // ---------------------------------------------------------------------------
  call_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .call_led   (call_led_reg),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up_reg),
    .pick_floor (pick_floor),
    .pick_valid (pick_valid),
    .dir_next   (dir_next)
  );

  // ---------------------------------------------------------------------------
  // Call latch set/clear terms
  // ---------------------------------------------------------------------------
  // While the car stands at a floor (IDLE or DWELL) a press for that floor is
  // served on the spot rather than latched.
  assign block_here  = (state_reg == ST_IDLE) || (state_reg == ST_DWELL);
  assign arrive_goal = (state_reg == ST_MOVING) && arrived && (cur_floor == goal_floor_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_call
      assign here_req[gi] = (int'(cur_floor) == gi);
      assign call_set[gi] = call_req[gi] && !(block_here && here_req[gi]);
      assign call_clr[gi] = arrive_goal && (int'(goal_floor_reg) == gi);
    end
  endgenerate

  assign serving_call = (state_reg == ST_DWELL) && (|(call_req & here_req));

  // Clear is applied after set so a press for the goal floor in its clear
  // cycle does not survive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      call_led_reg <= '0;
    end else if (sos_enter || (state_reg == ST_SOS)) begin
      call_led_reg <= '0;
    end else begin
      call_led_reg <= (call_led_reg | call_set) & ~call_clr;
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      goal_floor_reg <= '0;
      goal_valid_reg <= 1'b0;
      dir_up_reg     <= 1'b1;
      dwell_cnt_reg  <= '0;
      sos_home_reg   <= 1'b0;
    end else if (sos_enter) begin
      state_reg      <= ST_SOS;
      goal_floor_reg <= FLOOR_W'(F1);
      goal_valid_reg <= 1'b1;
      sos_home_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid && !weight_over) begin
            goal_floor_reg <= pick_floor;
            dir_up_reg     <= dir_next;
            goal_valid_reg <= 1'b1;
            state_reg      <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          if (goal_bus.goal_ack) begin
            goal_valid_reg <= 1'b0;
            state_reg      <= ST_MOVING;
          end
        end

        ST_MOVING: begin
          if (arrive_goal) begin
            dwell_cnt_reg <= DWELL_RELOAD;
            state_reg     <= ST_DWELL;
          end
        end

        ST_DWELL: begin
          // Overload or a fresh press at this floor holds the doors open.
          if (weight_over || serving_call) begin
            dwell_cnt_reg <= DWELL_RELOAD;
          end else if (dwell_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg - 1'b1;
          end
        end

        ST_SOS: begin
          // Three phases: wait for ack, wait for arrival at floor 0, then
          // hold there until the recall request is withdrawn.
          if (goal_valid_reg) begin
            if (goal_bus.goal_ack) goal_valid_reg <= 1'b0;
          end else if (!sos_home_reg) begin
            if (arrived && (cur_floor == FLOOR_W'(F1))) sos_home_reg <= 1'b1;
          end else if (!sos_level) begin
            sos_home_reg <= 1'b0;
            dir_up_reg   <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign goal_bus.goal_floor = goal_floor_reg;
  assign goal_bus.goal_valid = goal_valid_reg;
  assign call_led            = call_led_reg;
  assign dir_up              = dir_up_reg;
  assign busy                = (state_reg != ST_IDLE);

endmodule
